// File: rtl/scratch_mem_sequencer.sv
// Command sequencer for a small byte-wide scratch memory: clear, burst write,
// burst read and looping playback, with ready/valid data streams in and out.
module scratch_mem_sequencer #(
    parameter int DEPTH = 10,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_base,
    input  logic [AW-1:0] cmd_len,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    input  logic          stop,
    output logic          busy,
    output logic          done,
    output logic          err
);
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WRITE, S_READ, S_LOOP, S_DONE} state_t;

    localparam logic [1:0]    OP_CLEAR = 2'b00;
    localparam logic [1:0]    OP_WRITE = 2'b01;
    localparam logic [1:0]    OP_READ  = 2'b10;
    localparam logic [AW-1:0] DEPTH_W  = AW'(DEPTH);
    localparam logic [AW-1:0] LAST_W   = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE_W    = AW'(1);

    logic [DW-1:0] mem [DEPTH];

    state_t        state_reg, state_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [AW-1:0] count_reg, count_next;
    logic [AW-1:0] base_reg, base_next;
    logic [AW-1:0] len_reg, len_next;
    logic [DW-1:0] rd_data_reg;
    logic          rd_valid_reg, rd_valid_next;
    logic          err_reg, err_next;
    logic          mem_we, mem_re;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [AW-1:0] len_eff;
    logic          cmd_illegal;

    // Address arithmetic wraps at DEPTH, not at the power of two.
    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
        return (a == LAST_W) ? '0 : a + ONE_W;
    endfunction

    assign len_eff     = (cmd_len == '0) ? DEPTH_W : cmd_len;
    assign cmd_illegal = (cmd_base >= DEPTH_W) || (cmd_len > DEPTH_W);

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        count_next    = count_reg;
        base_next     = base_reg;
        len_next      = len_reg;
        rd_valid_next = rd_valid_reg;
        err_next      = err_reg;
        mem_we        = 1'b0;
        mem_wdata     = '0;
        mem_re        = 1'b0;
        mem_raddr     = addr_reg;
        case (state_reg)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_illegal) begin
                        err_next = 1'b1;
                    end else begin
                        base_next  = cmd_base;
                        len_next   = len_eff;
                        addr_next  = cmd_base;
                        count_next = len_eff;
                        case (cmd_op)
                            OP_CLEAR: begin
                                state_next = S_CLEAR;
                                addr_next  = '0;
                                count_next = DEPTH_W;
                                err_next   = 1'b0;
                            end
                            OP_WRITE: state_next = S_WRITE;
                            OP_READ:  state_next = S_READ;
                            default:  state_next = S_LOOP;
                        endcase
                    end
                end
            end
            S_CLEAR: begin
                mem_we     = 1'b1;
                addr_next  = wrap_inc(addr_reg);
                count_next = count_reg - ONE_W;
                if (count_reg == ONE_W) state_next = S_DONE;
            end
            S_WRITE: begin
                if (wr_valid) begin
                    mem_we     = 1'b1;
                    mem_wdata  = wr_data;
                    addr_next  = wrap_inc(addr_reg);
                    count_next = count_reg - ONE_W;
                    if (count_reg == ONE_W) state_next = S_DONE;
                end
            end
            S_READ, S_LOOP: begin
                // rd_valid low here only on the first cycle: prime the output register.
                if (!rd_valid_reg) begin
                    mem_re        = 1'b1;
                    rd_valid_next = 1'b1;
                    addr_next     = wrap_inc(addr_reg);
                end else if (rd_ready) begin
                    if (state_reg == S_LOOP && stop) begin
                        rd_valid_next = 1'b0;
                        state_next    = S_DONE;
                    end else if (count_reg > ONE_W) begin
                        mem_re     = 1'b1;
                        addr_next  = wrap_inc(addr_reg);
                        count_next = count_reg - ONE_W;
                    end else if (state_reg == S_LOOP) begin
                        mem_re     = 1'b1;
                        mem_raddr  = base_reg;
                        addr_next  = wrap_inc(base_reg);
                        count_next = len_reg;
                    end else begin
                        rd_valid_next = 1'b0;
                        state_next    = S_DONE;
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            addr_reg     <= '0;
            count_reg    <= '0;
            base_reg     <= '0;
            len_reg      <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            count_reg    <= count_next;
            base_reg     <= base_next;
            len_reg      <= len_next;
            rd_valid_reg <= rd_valid_next;
            err_reg      <= err_next;
            if (mem_re) rd_data_reg <= mem[mem_raddr];
        end
    end

    // Storage is not reset; a write coinciding with reset is dropped with the command.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) mem[addr_reg] <= mem_wdata;
    end

    assign cmd_ready = (state_reg == S_IDLE);
    assign wr_ready  = (state_reg == S_WRITE);
    assign busy      = (state_reg != S_IDLE);
    assign done      = (state_reg == S_DONE);
    assign err       = err_reg;
    assign rd_data   = rd_data_reg;
    assign rd_valid  = rd_valid_reg;
endmodule
